// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine that owns the HI/LO registers and stalls EX while busy.
// Define MULDIV_FAST_MUL_EN to form products with a single-cycle multiplier (IDLE -> FIX -> IDLE).
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             flush,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [5:0] F_MTHI = 6'h11;
   localparam logic [5:0] F_MTLO = 6'h13;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [2*WIDTH-1:0]     acc_q;
   logic [WIDTH-1:0]       a_q, b_q;
   logic                   sign_a_q, sign_b_q, div_q, done_q;

   logic                   accept, is_md, is_signed, last_iter;
   logic [WIDTH-1:0]       rs_mag, rt_mag;
   logic [WIDTH:0]         mul_sum, rem_sh, div_diff;
   logic [2*WIDTH-1:0]     mul_next, div_next, prod, prod_s;
   logic [WIDTH-1:0]       quot, rem, res_hi, res_lo;

   assign accept    = (state_q == S_IDLE) && req && !flush;
   assign is_md     = (funct[5:2] == 4'b0110);
   assign is_signed = !funct[0];
   assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
   assign rs_mag    = (is_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
   assign rt_mag    = (is_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;

   assign busy  = (state_q != S_IDLE);
   assign stall = busy && req;
   assign done  = done_q;

   // One radix-2 step: multiplier bits shift out of the low half as the product grows in the high half
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
   assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
   assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_diff = rem_sh - {1'b0, b_q};
   assign div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept && is_md) begin
`ifdef MULDIV_FAST_MUL_EN
               state_d = funct[1] ? S_RUN : S_FIX;
`else
               state_d = S_RUN;
`endif
            end
         end
         S_RUN: begin
            if (flush)
               state_d = S_IDLE;
            else if (last_iter)
               state_d = S_FIX;
         end
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      prod = acc_q;
`ifdef MULDIV_FAST_MUL_EN
      prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`endif
      prod_s = (sign_a_q ^ sign_b_q) ? -prod : prod;
      quot   = acc_q[WIDTH-1:0];
      rem    = acc_q[2*WIDTH-1:WIDTH];
      res_hi = prod_s[2*WIDTH-1:WIDTH];
      res_lo = prod_s[WIDTH-1:0];
      if (div_q) begin
         // Divide by zero hands back the dividend exactly as it arrived, rebuilt from its magnitude
         if (b_q == '0) begin
            res_lo = '1;
            res_hi = sign_a_q ? -a_q : a_q;
         end else begin
            res_lo = (sign_a_q ^ sign_b_q) ? -quot : quot;
            res_hi = sign_a_q ? -rem : rem;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         div_q    <= 1'b0;
         done_q   <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (funct == F_MTHI) hi <= rs_data;
                  if (funct == F_MTLO) lo <= rs_data;
                  if (is_md) begin
                     a_q      <= rs_mag;
                     b_q      <= rt_mag;
                     sign_a_q <= is_signed && rs_data[WIDTH-1];
                     sign_b_q <= is_signed && rt_data[WIDTH-1];
                     div_q    <= funct[1];
                     acc_q    <= funct[1] ? {{WIDTH{1'b0}}, rs_mag} : {{WIDTH{1'b0}}, rt_mag};
                     cnt_q    <= '0;
                  end
               end
            end
            S_RUN: begin
               if (flush) begin
                  cnt_q <= '0;
               end else begin
                  acc_q <= div_q ? div_next : mul_next;
                  cnt_q <= last_iter ? '0 : cnt_q + CNT_W'(1);
               end
            end
            S_FIX: begin
               if (!flush) begin
                  hi     <= res_hi;
                  lo     <= res_lo;
                  done_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
